count_capture: RTL and testbench
================================

Name: count_capture

Overview:
- Monitor stage directly downstream of the 8-bit free-running counter and its 2-bit adder side output.
- Watches the counter value (cnt_in) and the adder result (cc_in) and detects three event types: counter wrap, threshold crossing, and cc change.
- Each detected event is pushed as a 12-bit record into a small synchronous FIFO.
- Records drain to a consumer over a valid/ready handshake.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CNT_W, 8: counter width; record width = CNT_W+4.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- arm  in  1  level; 1 = enable event detection
- cnt_in  in  CNT_W  counter value from upstream, registered upstream
- cc_in  in  2  adder result from upstream
- thresh  in  CNT_W  threshold; quasi-static, sampled every cycle
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  CNT_W+4  record {evt[1:0], cc[1:0], cnt[CNT_W-1:0]}
- armed  out  1  high in state RUN
- drop_cnt  out  8  events lost to a full FIFO; saturates at 255

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. rst takes priority over every other input.
- Reset values: state=IDLE, FIFO empty, out_valid=0, out_data=0, armed=0, drop_cnt=0, prev_cnt=0, prev_cc=0.
- rst mid-operation discards all FIFO contents in that same edge.
- FSM states: IDLE, PRIME, RUN.
  - IDLE -> PRIME when arm=1.
  - PRIME: loads prev_cnt/prev_cc; no detection. Always -> RUN next cycle.
  - RUN -> IDLE when arm=0. Otherwise stay.
  - Deassert in PRIME: still enter RUN, then exit next cycle on arm=0.
- prev_cnt/prev_cc register cnt_in/cc_in every cycle in all states except reset.
- Detection is combinational, RUN only, and compares current inputs against prev_*:
  - WRAP (evt=2'b01): prev_cnt==all-ones && cnt_in==0. Any other transition to 0 (e.g. upstream reset) is not a wrap.
  - THRESH (evt=2'b10): prev_cnt<thresh && cnt_in>=thresh, unsigned compare. thresh==0 never fires.
  - CCCHG (evt=2'b11): cc_in != prev_cc.
- At most one record per cycle. Priority WRAP > THRESH > CCCHG; lower-priority coincident events are discarded silently and are not counted as drops.
- Record fields carry the current cnt_in and cc_in values.
- Push occurs on the same edge as detection. out_valid rises on the following cycle; there is no fall-through.
- Pop: out_valid && out_ready.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - Pop on an empty FIFO is a no-op.
- Full FIFO:
  - Push with a simultaneous pop is accepted; occupancy stays DEPTH.
  - Push without a pop is dropped and drop_cnt increments, saturating at 255.
- Leaving RUN stops detection only; queued records continue to drain.
- drop_cnt clears only on rst.
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. Full/empty are derived from the MSB comparison.

Decomposition:
- Package count_capture_pkg holds:
  - evt_t enum: EVT_WRAP=2'b01, EVT_THRESH=2'b10, EVT_CCCHG=2'b11.
  - state_t enum: IDLE, PRIME, RUN.
  - Record field widths/offsets as localparams.
- Sub-module cap_fifo: generic synchronous FIFO, parameters WIDTH and DEPTH.
  - Ports: push, push_data, full, pop, head_data, empty.
  - Behaviour: registered head; simultaneous push/pop at full is allowed.
- Top level keeps the FSM, detection, priority encode and drop counter.

Test Plan:
- Reset with arm=1 and 2 entries queued -> next cycle out_valid=0, drop_cnt=0, armed=0, and the queued records never appear.
- arm=1, cnt_in steps 8'hFE, 8'hFF, 8'h00, cc_in constant, out_ready=1 -> exactly one record 12'b01_cc_00000000. out_valid is high for one cycle, starting the cycle after the 8'hFF->8'h00 edge.
- thresh=8'd10, cnt_in 9->10, cc_in changes 2'b00->2'b01 on the same cycle -> single record {2'b10, 2'b01, 8'd10}; no CCCHG record.
- thresh=0 and cnt_in sweeps 0..255 -> only a WRAP record at the 255->0 transition.
- out_ready=0 and 6 cc toggles with DEPTH=4 -> 4 records held with out_data stable, drop_cnt=2. Then out_ready=1 -> the 4 records drain in order.
- FIFO full with a simultaneous event and pop -> the event is accepted, drop_cnt unchanged, occupancy stays 4.
- arm pulsed 1 for one cycle -> sequence IDLE->PRIME->RUN->IDLE, armed high for exactly 1 cycle. A cnt_in change during PRIME produces no record.

Source files
------------

// File: rtl/count_capture_pkg.sv
// Shared types and record layout for the count_capture monitor.
package count_capture_pkg;

  // Event code carried in the top two bits of every record.
  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_WRAP   = 2'b01,
    EVT_THRESH = 2'b10,
    EVT_CCCHG  = 2'b11
  } evt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    RUN   = 2'b10
  } state_t;

  // Record layout, LSB first: cnt[CNT_W-1:0], cc[1:0], evt[1:0].
  localparam int CC_W  = 2;
  localparam int EVT_W = 2;
  localparam int REC_TAG_W = CC_W + EVT_W;  // bits added on top of the count

endpackage

// File: rtl/cap_fifo.sv
// Small synchronous FIFO. The head is read from registered storage,
// so a pushed word becomes visible one cycle after the push edge.
module cap_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_pop, do_push;

  // Extra pointer MSB tells full (wrapped once more) from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // At full, a same-cycle pop frees the slot being written.
  assign do_push = push && (!full || do_pop);

  assign head_data = mem[rd_ptr[AW-1:0]];

  // Storage and pointers; reset clears contents so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/count_capture.sv
// Watches the upstream counter and adder output, turns wrap / threshold
// crossing / cc change events into records and queues them for a consumer.
module count_capture
  import count_capture_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [CNT_W-1:0]      cnt_in,
  input  logic [1:0]            cc_in,
  input  logic [CNT_W-1:0]      thresh,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W+REC_TAG_W-1:0] out_data,
  output logic                  armed,
  output logic [7:0]            drop_cnt
);

  localparam int REC_W = CNT_W + REC_TAG_W;

  state_t           state;
  logic [CNT_W-1:0] prev_cnt;
  logic [1:0]       prev_cc;
  evt_t             evt;
  logic             fire, hit_wrap, hit_thresh, hit_cc;
  logic             full, empty, popping;
  logic [REC_W-1:0] rec;

  // FSM: PRIME gives prev_* one clean sample before detection starts.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else begin
      case (state)
        IDLE:    if (arm) state <= PRIME;
        PRIME:   state <= RUN;
        RUN:     if (!arm) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Previous-sample registers track the inputs in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cnt <= '0;
      prev_cc  <= '0;
    end else begin
      prev_cnt <= cnt_in;
      prev_cc  <= cc_in;
    end
  end

  // A drop to zero only counts as a wrap when coming from all-ones.
  assign hit_wrap   = (prev_cnt == {CNT_W{1'b1}}) && (cnt_in == '0);
  assign hit_thresh = (prev_cnt < thresh) && (cnt_in >= thresh);
  assign hit_cc     = (cc_in != prev_cc);

  // Priority encode; losing coincident events are simply discarded.
  always_comb begin
    evt = EVT_NONE;
    if (state == RUN) begin
      if (hit_wrap)        evt = EVT_WRAP;
      else if (hit_thresh) evt = EVT_THRESH;
      else if (hit_cc)     evt = EVT_CCCHG;
    end
  end

  assign fire    = (evt != EVT_NONE);
  assign rec     = {evt, cc_in, cnt_in};
  assign popping = out_ready && !empty;

  cap_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fire),
    .push_data (rec),
    .full      (full),
    .pop       (out_ready),
    .head_data (out_data),
    .empty     (empty)
  );

  assign out_valid = !empty;
  assign armed     = (state == RUN);

  // Count events lost to a full FIFO with no pop to make room.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else if (fire && full && !popping && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_count_capture.sv
// Bench for count_capture: directed scenarios plus a randomized run, all
// checked against a queue-based model of the record stream.
module tb_count_capture;

  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst, arm, out_ready, out_valid, armed;
  logic [7:0]  cnt_in, thresh, drop_cnt;
  logic [1:0]  cc_in;
  logic [11:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0=idle, 1=priming, 2=running.
  int          ph;
  logic [7:0]  m_pcnt;
  logic [1:0]  m_pcc;
  logic [11:0] mq[$];
  int          m_drop;

  count_capture #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .arm(arm), .cnt_in(cnt_in), .cc_in(cc_in),
    .thresh(thresh), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .armed(armed), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // One clock edge: advance the model with the inputs present at the edge.
  task automatic cyc();
    logic [1:0] e;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_drop = 0; ph = 0; m_pcnt = 0; m_pcc = 0;
    end else begin
      e = 2'b00;
      if (ph == 2) begin
        if (m_pcnt == 8'hFF && cnt_in == 8'h00) e = 2'b01;
        else if (m_pcnt < thresh && cnt_in >= thresh) e = 2'b10;
        else if (cc_in != m_pcc) e = 2'b11;
      end
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (e != 2'b00) begin
        if (mq.size() < DEPTH) mq.push_back({e, cc_in, cnt_in});
        else if (m_drop < 255) m_drop++;
      end
      case (ph)
        0: if (arm) ph = 1;
        1: ph = 2;
        default: if (!arm) ph = 0;
      endcase
      m_pcnt = cnt_in; m_pcc = cc_in;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; arm = 0; cnt_in = 0; cc_in = 0; thresh = 0; out_ready = 0;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 12'h000) begin n_err++; $display("FAIL reset_data got %h want 000", out_data); end
    n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL reset_armed got %b want 0", armed); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    arm = 1; cnt_in = 8'h05; cc_in = 0;
    cyc(); cyc(); cyc();
    cc_in = 1; cyc();
    cc_in = 2; cyc();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
    rst = 1; cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL rst_mid_armed got %b want 0", armed); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rst_mid_drop got %0d want 0", drop_cnt); end
    rst = 0; arm = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_flushed cyc %0d valid %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [4];
    int nval, first;
    seq[0] = 8'hFF; seq[1] = 8'h00; seq[2] = 8'h00; seq[3] = 8'h00;
    do_reset();
    arm = 1; cc_in = 2'b10; out_ready = 1; cnt_in = 8'hFE;
    cyc(); cyc(); cyc();
    nval = 0; first = -1;
    for (int i = 0; i < 4; i++) begin
      cnt_in = seq[i]; cyc();
      n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL wrap_valid cyc %0d got %b model %0d", i, out_valid, mq.size()); end
      if (out_valid) begin
        nval++; if (first < 0) first = i;
        n_cmp++; if (out_data !== 12'h600) begin n_err++; $display("FAIL wrap_data got %h want 600", out_data); end
      end
    end
    n_cmp++; if (nval != 1 || first != 1) begin n_err++; $display("FAIL wrap_count got %0d first %0d want 1 first 1", nval, first); end
  endtask

  task automatic test_thresh();
    do_reset();
    thresh = 8'd10; arm = 1; cnt_in = 8'd9; cc_in = 2'b00; out_ready = 1;
    cyc(); cyc(); cyc();
    cnt_in = 8'd10; cc_in = 2'b01; cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 12'h90A) begin n_err++; $display("FAIL thresh_rec got v%b %h want v1 90A", out_valid, out_data); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL thresh_single got %b want 0", out_valid); end
  endtask

  task automatic test_thresh0();
    int nrec;
    logic [8:0] v;
    do_reset();
    thresh = 0; arm = 1; cc_in = 0; cnt_in = 0; out_ready = 1;
    cyc(); cyc(); cyc();
    nrec = 0;
    for (int i = 1; i <= 257; i++) begin
      v = 9'(i); cnt_in = v[7:0]; cyc();
      if (out_valid) begin
        nrec++;
        n_cmp++; if (out_data !== 12'h400) begin n_err++; $display("FAIL thr0_data at %0d got %h want 400", i, out_data); end
      end
    end
    n_cmp++; if (nrec != 1) begin n_err++; $display("FAIL thr0_count got %0d want 1", nrec); end
  endtask

  task automatic test_full_drop();
    logic [11:0] exp [6];
    logic [1:0]  c;
    do_reset();
    arm = 1; cnt_in = 8'h30; cc_in = 0; out_ready = 0;
    cyc(); cyc(); cyc();
    for (int k = 0; k < 6; k++) begin
      c = (k % 2 == 0) ? 2'b01 : 2'b00;
      cc_in = c; cnt_in = 8'h31 + 8'(k);
      exp[k] = {2'b11, c, cnt_in};
      cyc();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp[0]) begin n_err++; $display("FAIL hold_head cyc %0d got v%b %h want v1 %h", k, out_valid, out_data, exp[0]); end
    end
    n_cmp++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL drop_two got %0d want 2", drop_cnt); end
    arm = 0; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp[k]) begin n_err++; $display("FAIL drain_order %0d got v%b %h want v1 %h", k, out_valid, out_data, exp[k]); end
      cyc();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", out_valid); end
  endtask

  task automatic test_full_pop();
    int n;
    logic [11:0] last;
    do_reset();
    arm = 1; cnt_in = 8'h40; cc_in = 0; out_ready = 0;
    cyc(); cyc(); cyc();
    for (int k = 0; k < 4; k++) begin
      cc_in = cc_in ^ 2'b01; cnt_in = 8'h41 + 8'(k); cyc();
    end
    cc_in = cc_in ^ 2'b01; cnt_in = 8'h50; out_ready = 1; cyc();
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL fullpop_drop got %0d want 0", drop_cnt); end
    arm = 0;
    n = 0; last = '0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        n++; last = out_data;
        n_cmp++; if (mq.size() == 0 || out_data !== mq[0]) begin n_err++; $display("FAIL fullpop_data %0d got %h", i, out_data); end
      end
      cyc();
    end
    n_cmp++; if (n != 4) begin n_err++; $display("FAIL fullpop_occ got %0d want 4", n); end
    n_cmp++; if (last !== {2'b11, cc_in, 8'h50}) begin n_err++; $display("FAIL fullpop_last got %h want %h", last, {2'b11, cc_in, 8'h50}); end
  endtask

  task automatic test_arm_pulse();
    int na, nv;
    do_reset();
    thresh = 8'h18; out_ready = 1; cnt_in = 8'h10; cc_in = 0; arm = 1;
    cyc();
    arm = 0; cnt_in = 8'h20; cc_in = 2'b11;
    na = 0; nv = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (armed) na++;
      if (out_valid) nv++;
    end
    n_cmp++; if (na != 1) begin n_err++; $display("FAIL pulse_armed got %0d want 1", na); end
    n_cmp++; if (nv != 0) begin n_err++; $display("FAIL pulse_norec got %0d want 0", nv); end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      arm = ($urandom_range(0, 15) != 0);
      case ($urandom_range(0, 9))
        0: cnt_in = 8'($urandom);
        1: cnt_in = 8'h00;
        2: cnt_in = 8'hFF;
        default: cnt_in = cnt_in + 8'd1;
      endcase
      if ($urandom_range(0, 3) == 0) cc_in = 2'($urandom);
      if ($urandom_range(0, 63) == 0) thresh = 8'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      cyc();
      n_cmp++;
      if (out_valid !== (mq.size() > 0) || armed !== (ph == 2) || drop_cnt !== 8'(m_drop) ||
          (mq.size() > 0 && out_data !== mq[0])) begin
        n_err++;
        if (bad < 10) $display("FAIL random cyc %0d got v%b d%h a%b dr%0d want v%0d a%0d dr%0d d%h",
          i, out_valid, out_data, armed, drop_cnt, mq.size() > 0, ph == 2, m_drop, (mq.size() > 0) ? mq[0] : 12'h000);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_thresh();
    test_thresh0();
    test_full_drop();
    test_full_pop();
    test_arm_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
